// File: rtl/alu_wb_pkg.sv
// Shared opcode, flag-index and entry definitions for the ALU writeback stage.
package alu_wb_pkg;

    localparam int WB_WIDTH = 4;

    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [2:0]          op;
        logic [WB_WIDTH-1:0] result;
        logic [3:0]          flags;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback bundle channel and writeback-to-consumer channel, valid/ready on both.
interface alu_wb_stage_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_result;
    logic             in_cout;
    logic             in_set;
    logic             in_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_op;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;

    // Stage side.
    modport slave (
        input  in_valid, in_op, in_result, in_cout, in_set, in_overflow, out_ready,
        output in_ready, out_valid, out_op, out_result, out_flags
    );

    // ALU producer plus downstream consumer side.
    modport master (
        output in_valid, in_op, in_result, in_cout, in_set, in_overflow, out_ready,
        input  in_ready, out_valid, out_op, out_result, out_flags
    );
endinterface

// File: rtl/alu_wb_fifo.sv
// Generic synchronous FIFO; entry visible on pop side one cycle after push, no bypass.
// Push refused while full, pop ignored while empty; head data reads as zero when empty.
module alu_wb_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_rdy_i,
    output logic [DW-1:0] pop_dat_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign push    = push_vld_i & ~full_o;
    assign pop     = pop_rdy_i & ~empty_o;

    // Zero while empty so the idle output bus is deterministic after reset.
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback/flag stage: Z/N/C/V derivation, DEPTH-entry buffer, sticky overflow, retire count.
// Latency 1 cycle push-to-head; in_ready is occupancy-only (no path from out_ready). ALU_WB_SLT_ZEXT_EN zero-extends SLT results.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_wb_stage_if.slave    bus,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] retired_cnt
);
    // Same layout as wb_entry_t, widened to follow WIDTH.
    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
    } entry_t;

    logic [WIDTH-1:0] result_final;
    logic [3:0]       flags;
    entry_t           push_ent, head_ent;
    logic             full, empty, push, pop;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] retired_q, retired_d;

`ifdef ALU_WB_SLT_ZEXT_EN
    always_comb begin
        result_final = bus.in_result;
        if (bus.in_op == OP_SLT) result_final = {{(WIDTH-1){1'b0}}, bus.in_set};
    end
`else
    logic unused_in_set;
    assign unused_in_set = bus.in_set;
    assign result_final  = bus.in_result;
`endif

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result_final == '0);
        flags[FLAG_N] = result_final[WIDTH-1];
        flags[FLAG_C] = bus.in_cout;
        flags[FLAG_V] = bus.in_overflow;
    end

    assign push_ent = '{op: bus.in_op, result: result_final, flags: flags};
    assign push     = bus.in_valid & ~full;
    assign pop      = bus.out_ready & ~empty;

    alu_wb_fifo #(
        .DW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (bus.in_valid),
        .push_dat_i (push_ent),
        .pop_rdy_i  (bus.out_ready),
        .pop_dat_o  (head_ent),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = ~empty;
    assign bus.out_op     = head_ent.op;
    assign bus.out_result = head_ent.result;
    assign bus.out_flags  = head_ent.flags;

    // A new overflow in the same cycle as a clear must survive.
    always_comb begin
        sticky_d  = (push & bus.in_overflow) | (sticky_q & ~clr_sticky);
        retired_d = pop ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            sticky_q  <= sticky_d;
            retired_q <= retired_d;
        end
    end

    assign sticky_ovf  = sticky_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed pushes queue expected entries, a negedge monitor checks pops.
module tb_alu_wb_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sticky_ovf;
    logic       clr_sticky;
    logic [7:0] retired_cnt;

    always #5 clk = ~clk;

    alu_wb_stage_if #(.WIDTH(4)) bus ();

    alu_wb_stage #(
        .WIDTH (4),
        .DEPTH (2),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .sticky_ovf  (sticky_ovf),
        .clr_sticky  (clr_sticky),
        .retired_cnt (retired_cnt)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] res;
        logic [3:0] flags;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid & ready hold mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got op=%0h res=%0h flags=%0h expected no output",
                         bus.out_op, bus.out_result, bus.out_flags);
            end else begin
                e = sb.pop_front();
                chk("out_op", {29'd0, bus.out_op}, {29'd0, e.op});
                chk("out_result", {28'd0, bus.out_result}, {28'd0, e.res});
                chk("out_flags", {28'd0, bus.out_flags}, {28'd0, e.flags});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] res, input logic cout,
                        input logic set, input logic ovf,
                        input logic [3:0] eres, input logic [3:0] eflags);
        int   w;
        exp_t e;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        if (w == 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=%b expected 1 within 20 cycles", bus.in_ready);
        end else begin
            bus.in_valid    = 1'b1;
            bus.in_op       = op;
            bus.in_result   = res;
            bus.in_cout     = cout;
            bus.in_set      = set;
            bus.in_overflow = ovf;
            e.op    = op;
            e.res   = eres;
            e.flags = eflags;
            sb.push_back(e);
            step();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid === 1'b1 && w < 20) begin
            step();
            w++;
        end
        if (w == 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got out_valid=%b expected 0 within 20 cycles", bus.out_valid);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        clr_sticky      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_op       = 3'd0;
        bus.in_result   = 4'd0;
        bus.in_cout     = 1'b0;
        bus.in_set      = 1'b0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_out_op", {29'd0, bus.out_op}, 0);
        chk("rst_out_result", {28'd0, bus.out_result}, 0);
        chk("rst_out_flags", {28'd0, bus.out_flags}, 0);
        chk("rst_sticky", {31'd0, sticky_ovf}, 0);
        chk("rst_retired", {24'd0, retired_cnt}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        rst_n = 1'b1;

        // Empty with out_ready=1: no pop
        bus.out_ready = 1'b1;
        step();
        chk("empty_no_pop", {24'd0, retired_cnt}, 0);

        // Basic push, one-cycle latency, flags Z=1 C=1
        chk("no_bypass_valid", {31'd0, bus.out_valid}, 0);
        send(3'b001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010);
        chk("lat_out_valid", {31'd0, bus.out_valid}, 1);
        chk("lat_out_flags", {28'd0, bus.out_flags}, 32'b1010);
        step();
        chk("retired_after_1", {24'd0, retired_cnt}, 1);

        // Fill, hold a third bundle, single pop while full
        bus.out_ready = 1'b0;
        send(3'b010, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000);
        send(3'b011, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0110);
        chk("full_in_ready", {31'd0, bus.in_ready}, 0);
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'b100;
        bus.in_result = 4'b0011;
        bus.in_cout   = 1'b0;
        step();
        step();
        chk("held_in_ready", {31'd0, bus.in_ready}, 0);
        chk("stable_out_op", {29'd0, bus.out_op}, 32'b010);
        chk("stable_out_result", {28'd0, bus.out_result}, 32'b0101);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("in_ready_after_pop", {31'd0, bus.in_ready}, 1);
        chk("head_after_pop", {29'd0, bus.out_op}, 32'b011);
        sb.push_back(exp_t'{op: 3'b100, res: 4'b0011, flags: 4'b0000});
        step();
        bus.in_valid = 1'b0;
        chk("refull_in_ready", {31'd0, bus.in_ready}, 0);
        drain();
        chk("retired_after_4", {24'd0, retired_cnt}, 4);

        // Sticky overflow: set, set-wins-over-clear, clear
        send(3'b000, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0101);
        chk("sticky_set", {31'd0, sticky_ovf}, 1);
        clr_sticky = 1'b1;
        send(3'b001, 4'b0111, 1'b0, 1'b0, 1'b1, 4'b0111, 4'b0001);
        chk("sticky_set_wins", {31'd0, sticky_ovf}, 1);
        step();
        clr_sticky = 1'b0;
        chk("sticky_cleared", {31'd0, sticky_ovf}, 0);
        drain();
        chk("retired_after_6", {24'd0, retired_cnt}, 6);

        // SLT handling
`ifdef ALU_WB_SLT_ZEXT_EN
        send(3'b111, 4'b1101, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);
        send(3'b111, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000);
`else
        send(3'b111, 4'b1101, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b0100);
        send(3'b111, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000);
`endif
        send(3'b110, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000);
        drain();
        chk("retired_after_9", {24'd0, retired_cnt}, 9);

        // Reset with two entries buffered
        bus.out_ready = 1'b0;
        send(3'b010, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001);
        send(3'b011, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010);
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
        chk("pre_rst_sticky", {31'd0, sticky_ovf}, 1);
        rst_n = 1'b0;
        sb.delete();
        step();
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("mid_rst_out_result", {28'd0, bus.out_result}, 0);
        chk("mid_rst_retired", {24'd0, retired_cnt}, 0);
        chk("mid_rst_sticky", {31'd0, sticky_ovf}, 0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) step();
        chk("no_emit_after_rst", {24'd0, retired_cnt}, 0);

        // Retired counter wrap 255 -> 0
        for (int i = 0; i < 255; i++) begin
            send(3'b101, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000);
        end
        drain();
        chk("retired_255", {24'd0, retired_cnt}, 255);
        send(3'b101, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000);
        drain();
        chk("retired_wrap", {24'd0, retired_cnt}, 0);

        step();
        chk("sb_all_seen", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
